// File: rtl/wbm_pkg.sv
// Shared FSM encoding and default constants for the Wishbone command initiator.
package wbm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUS,
        ST_RSP
    } state_t;

    localparam logic [31:0] ERR_DATA_DEF    = 32'hDEAD_BEEF;
    localparam int          TIMEOUT_CYC_DEF = 16;

    // Width of the BUS-cycle counter, $clog2(TIMEOUT_CYC), never narrower than one bit.
    function automatic int cnt_width(input int timeout_cyc);
        return (timeout_cyc < 2) ? 1 : $clog2(timeout_cyc);
    endfunction

endpackage

// File: rtl/wbm_cmd_initiator.sv
// Wishbone classic master: one valid/ready command becomes one single-beat bus cycle.
// Optional bus timeout is enabled with the WBM_TIMEOUT_EN macro.
module wbm_cmd_initiator
    import wbm_pkg::*;
#(
    parameter int              AW          = 32,
    parameter int              DW          = 32,
    parameter int              TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter logic [DW-1:0]   ERR_DATA    = DW'(ERR_DATA_DEF)
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [AW-1:0]     cmd_adr,
    input  logic [DW-1:0]     cmd_dat,
    input  logic [DW/8-1:0]   cmd_sel,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DW-1:0]     rsp_dat,
    output logic              rsp_err,
    output logic              wbm_cyc_o,
    output logic              wbm_stb_o,
    output logic              wbm_we_o,
    output logic [DW/8-1:0]   wbm_sel_o,
    output logic [AW-1:0]     wbm_adr_o,
    output logic [DW-1:0]     wbm_dat_o,
    input  logic              wbm_ack_i,
    input  logic [DW-1:0]     wbm_dat_i
);

    state_t            state_q, state_d;
    logic              cmd_ready_d, rsp_valid_d, cyc_d, we_d;
    logic [DW-1:0]     rsp_dat_d, wdat_d;
    logic [DW/8-1:0]   sel_d;
    logic [AW-1:0]     adr_d;

`ifdef WBM_TIMEOUT_EN
    localparam int CNT_W = cnt_width(TIMEOUT_CYC);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rsp_err_d;
`endif

    always_comb begin
        // NOTE: every next value defaults to its current one, so no branch can infer a latch.
        state_d     = state_q;
        cmd_ready_d = cmd_ready;
        rsp_valid_d = rsp_valid;
        rsp_dat_d   = rsp_dat;
        cyc_d       = wbm_cyc_o;
        we_d        = wbm_we_o;
        sel_d       = wbm_sel_o;
        adr_d       = wbm_adr_o;
        wdat_d      = wbm_dat_o;
`ifdef WBM_TIMEOUT_EN
        cnt_d       = cnt_q;
        rsp_err_d   = rsp_err;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    we_d        = cmd_we;
                    adr_d       = cmd_adr;
                    wdat_d      = cmd_dat;
                    sel_d       = cmd_sel;
                    cyc_d       = 1'b1;
                    cmd_ready_d = 1'b0;
                    state_d     = ST_BUS;
`ifdef WBM_TIMEOUT_EN
                    cnt_d       = '0;
`endif
                end
            end
            ST_BUS: begin
`ifdef WBM_TIMEOUT_EN
                cnt_d = cnt_q + 1'b1;
`endif
                if (wbm_ack_i) begin
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_dat_d   = wbm_we_o ? '0 : wbm_dat_i;
                    state_d     = ST_RSP;
`ifdef WBM_TIMEOUT_EN
                    rsp_err_d   = 1'b0;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    // Ack takes priority above; only a silent slave is aborted.
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_dat_d   = ERR_DATA;
                    rsp_err_d   = 1'b1;
                    state_d     = ST_RSP;
`endif
                end
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: reset is asynchronous so an in-flight bus cycle is dropped without waiting for a clock edge.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q   <= ST_IDLE;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_dat   <= '0;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= '0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register updating from pre-edge values.
            state_q   <= state_d;
            cmd_ready <= cmd_ready_d;
            rsp_valid <= rsp_valid_d;
            rsp_dat   <= rsp_dat_d;
            wbm_cyc_o <= cyc_d;
            wbm_stb_o <= cyc_d;
            wbm_we_o  <= we_d;
            wbm_sel_o <= sel_d;
            wbm_adr_o <= adr_d;
            wbm_dat_o <= wdat_d;
        end
    end

`ifdef WBM_TIMEOUT_EN
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            cnt_q   <= '0;
            rsp_err <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            rsp_err <= rsp_err_d;
        end
    end
`else
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_wbm_cmd_initiator.sv
// Bench for wbm_cmd_initiator: transaction-level model with a per-cycle compare process.
// Timeout scenarios run only when WBM_TIMEOUT_EN is defined.
module tb_wbm_cmd_initiator;

    localparam int AW     = 32;
    localparam int DW     = 32;
    localparam int SW     = DW / 8;
    localparam int TO_CYC = 16;
    localparam int LIMIT  = 200;
    localparam logic [31:0] BAD_DAT = 32'hBAD0_0000;
`ifdef WBM_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cmd_valid, cmd_ready, cmd_we;
    logic [AW-1:0] cmd_adr;
    logic [DW-1:0] cmd_dat;
    logic [SW-1:0] cmd_sel;
    logic          rsp_valid, rsp_ready, rsp_err;
    logic [DW-1:0] rsp_dat;
    logic          wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
    logic [SW-1:0] wbm_sel_o;
    logic [AW-1:0] wbm_adr_o;
    logic [DW-1:0] wbm_dat_o, wbm_dat_i;

    int checks = 0;
    int errors = 0;

    wbm_cmd_initiator #(
        .AW(AW), .DW(DW), .TIMEOUT_CYC(TO_CYC), .ERR_DATA(32'hDEAD_BEEF)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
        .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Slave: acks after ack_wait wait cycles, drives read data only on the ack cycle.
    int          ack_wait    = 0;
    logic [31:0] slave_rdata = '0;
    int          bus_cnt     = 0;

    always begin
        @(posedge clk);
        #1;
        if (rst || !(wbm_cyc_o && wbm_stb_o)) begin
            wbm_ack_i = 1'b0;
            wbm_dat_i = BAD_DAT;
            bus_cnt   = 0;
        end else begin
            wbm_ack_i = (bus_cnt == ack_wait);
            wbm_dat_i = (bus_cnt == ack_wait) ? slave_rdata : BAD_DAT;
            bus_cnt++;
        end
    end

    // Transaction model and compare process.
    typedef struct {
        int          len;
        logic [31:0] dat;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    bit          timed, busy, have_cmd, prev_cyc, prev_rv, prev_hs, seen_we;
    logic [31:0] cur_adr, cur_dat, prev_rdat, last_rdat;
    logic [3:0]  cur_sel;
    logic        cur_we, prev_rerr, last_rerr;
    int          sample = 0, cyc_len = 0, last_len = 0;
    int          last_acc = 0, last_rise = 0, last_hs = 0;

    always @(negedge clk) begin
        sample++;
        if (rst) begin
            exp_q.delete();
            busy = 0; have_cmd = 0; prev_cyc = 0; prev_rv = 0; prev_hs = 0; cyc_len = 0;
        end else begin
            check("stb_tracks_cyc", wbm_stb_o, wbm_cyc_o);
            check("cmd_ready", cmd_ready, !busy);
            if (wbm_cyc_o) begin
                cyc_len++;
                seen_we = wbm_we_o;
                check("bus_adr", wbm_adr_o, cur_adr);
                check("bus_dat", wbm_dat_o, cur_dat);
                check("bus_sel", wbm_sel_o, cur_sel);
                check("bus_we", wbm_we_o, cur_we);
                check("rsp_valid_during_bus", rsp_valid, 1'b0);
            end else if (have_cmd) begin
                check("idle_adr_kept", wbm_adr_o, cur_adr);
                check("idle_dat_kept", wbm_dat_o, cur_dat);
            end
            if (prev_cyc && !wbm_cyc_o) begin
                last_len = cyc_len;
                check("rsp_after_cyc", rsp_valid, 1'b1);
                if (exp_q.size() > 0) check("cyc_length", cyc_len, exp_q[0].len);
                cyc_len = 0;
            end
            if (rsp_valid) begin
                if (!prev_rv) last_rise = sample;
                if (exp_q.size() == 0) begin
                    check("rsp_valid_unexpected", rsp_valid, 1'b0);
                end else begin
                    if (prev_rv && !prev_hs) begin
                        check("rsp_dat_stable", rsp_dat, prev_rdat);
                        check("rsp_err_stable", rsp_err, prev_rerr);
                    end
                    if (rsp_ready) begin
                        check("rsp_dat", rsp_dat, exp_q[0].dat);
                        check("rsp_err", rsp_err, exp_q[0].err);
                        last_rdat = rsp_dat;
                        last_rerr = rsp_err;
                        last_hs   = sample;
                        void'(exp_q.pop_front());
                        busy = 0;
                    end
                end
            end
            if (cmd_valid && cmd_ready) begin
                cur_adr = cmd_adr; cur_dat = cmd_dat; cur_sel = cmd_sel; cur_we = cmd_we;
                have_cmd = 1; busy = 1; last_acc = sample;
                timed = TO_EN && (ack_wait >= TO_CYC);
                e.len = timed ? TO_CYC : ack_wait + 1;
                e.dat = timed ? 32'hDEAD_BEEF : (cmd_we ? 32'h0 : slave_rdata);
                e.err = timed;
                exp_q.push_back(e);
            end
            prev_cyc  = wbm_cyc_o;
            prev_rv   = rsp_valid;
            prev_hs   = rsp_valid && rsp_ready;
            prev_rdat = rsp_dat;
            prev_rerr = rsp_err;
        end
    end

    task automatic present(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel);
        cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel; cmd_valid = 1'b1;
    endtask

    task automatic wait_accept();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cmd_ready && n < LIMIT);
        if (!cmd_ready) check("accept_timeout", cmd_ready, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic get_rsp(input int hold);
        int n = 0;
        rsp_ready = (hold == 0);
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < LIMIT);
        if (!rsp_valid) begin
            check("rsp_timeout", rsp_valid, 1'b1);
            rsp_ready = 1'b0;
            return;
        end
        if (hold > 0) begin
            repeat (hold) @(negedge clk);
            @(posedge clk);
            #1;
            rsp_ready = 1'b1;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic xact(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input int wait_c, input logic [31:0] rdata);
        ack_wait = wait_c;
        slave_rdata = rdata;
        present(we, adr, dat, sel);
        wait_accept();
        cmd_valid = 1'b0;
        get_rsp(0);
    endtask

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        int          wait_c;
    } vec_t;

    vec_t vecs[6] = '{
        '{1'b0, 32'h3000_0010, 32'h0000_0000, 0},
        '{1'b1, 32'h3000_0014, 32'h0BAD_F00D, 3},
        '{1'b0, 32'h3000_0018, 32'h0000_0000, 7},
        '{1'b1, 32'h3000_001C, 32'hFFFF_0000, 1},
        '{1'b0, 32'h3000_0020, 32'h0000_0000, 2},
        '{1'b1, 32'h3000_0024, 32'h1357_9BDF, 0}
    };

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
        rsp_ready = 1'b0;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_cmd_ready", cmd_ready, 1'b1);
        check("reset_cyc", wbm_cyc_o, 1'b0);
        check("reset_stb", wbm_stb_o, 1'b0);
        check("reset_rsp_valid", rsp_valid, 1'b0);
        check("reset_rsp_dat", rsp_dat, 32'h0);
        check("reset_adr", wbm_adr_o, 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single write, immediate ack.
        xact(1'b1, 32'h3000_0004, 32'h0000_00A5, 4'hF, 0, 32'h0);
        check("t2_cyc_len", last_len, 1);
        check("t2_we", seen_we, 1'b1);
        check("t2_latency", last_rise - last_acc, 2);
        check("t2_rsp_dat", last_rdat, 32'h0);
        check("t2_rsp_err", last_rerr, 1'b0);

        // Read with five wait states.
        xact(1'b0, 32'h3000_0000, 32'h0, 4'hF, 5, 32'h1234_5678);
        check("t3_cyc_len", last_len, 6);
        check("t3_rsp_dat", last_rdat, 32'h1234_5678);
        check("t3_latency", last_rise - last_acc, 7);

        // Mixed reads and writes with random byte selects.
        foreach (vecs[i]) begin
            xact(vecs[i].we, vecs[i].adr, vecs[i].dat, 4'($urandom_range(1, 15)),
                 vecs[i].wait_c, $urandom);
        end

        // Stalled response with the next command already waiting.
        ack_wait = 2;
        slave_rdata = 32'hCAFE_0001;
        present(1'b0, 32'h3000_0040, 32'h0, 4'h3);
        wait_accept();
        present(1'b1, 32'h3000_0044, 32'h0000_7777, 4'hC);
        get_rsp(10);
        check("t4_rsp_dat", last_rdat, 32'hCAFE_0001);
        check("t4_hold_cycles", last_hs - last_rise, 11);
        wait_accept();
        cmd_valid = 1'b0;
        check("t4_accept_gap", last_acc - last_hs, 1);
        get_rsp(0);
        check("t4b_rsp_dat", last_rdat, 32'h0);

`ifdef WBM_TIMEOUT_EN
        // Silent slave aborts after TIMEOUT_CYC bus cycles; ack on the last cycle still wins.
        xact(1'b0, 32'h3000_0080, 32'h0, 4'hF, 1000, 32'h5555_AAAA);
        check("t5_to_len", last_len, 16);
        check("t5_to_err", last_rerr, 1'b1);
        check("t5_to_dat", last_rdat, 32'hDEAD_BEEF);
        xact(1'b0, 32'h3000_0084, 32'h0, 4'hF, 15, 32'h5555_AAAA);
        check("t5_ack_len", last_len, 16);
        check("t5_ack_err", last_rerr, 1'b0);
        check("t5_ack_dat", last_rdat, 32'h5555_AAAA);
`endif

        // Asynchronous reset in the middle of a bus cycle.
        ack_wait = 8;
        slave_rdata = 32'h0F0F_0F0F;
        present(1'b0, 32'h3000_00C0, 32'h0, 4'hF);
        wait_accept();
        cmd_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("t6_cyc_async", wbm_cyc_o, 1'b0);
        check("t6_stb_async", wbm_stb_o, 1'b0);
        check("t6_cmd_ready", cmd_ready, 1'b1);
        check("t6_rsp_valid", rsp_valid, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        xact(1'b0, 32'h3000_00C4, 32'h0, 4'h5, 1, 32'h2468_ACE0);
        check("t6_after_dat", last_rdat, 32'h2468_ACE0);
        check("t6_after_len", last_len, 2);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
